// File: rtl/hall_call_latch_if.sv
// Hall-call bus between the button front end and its environment.
// master drives raw buttons and served strobes; slave returns pulses, lamps and count.
interface hall_call_latch_if;
  logic [13:0] rawHallButton;
  logic [13:0] servedFloorButton;
  logic [13:0] newFloorButton;
  logic [13:0] hallLamp;
  logic [7:0]  callCount;

  modport master (
    output rawHallButton, servedFloorButton,
    input  newFloorButton, hallLamp, callCount
  );

  modport slave (
    input  rawHallButton, servedFloorButton,
    output newFloorButton, hallLamp, callCount
  );
endinterface

// File: rtl/hall_call_latch.sv
// Hall-call front end: synchronise, debounce, latch lamps, pulse new calls, count accepts.
// Define HALL_DEBOUNCE_EN to build the DEBOUNCE_CYCLES dwell counters; otherwise deb follows sync2.
module hall_call_latch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  hall_call_latch_if.slave hc
);
  // Floor 1 has no DOWN call and floor 7 has no UP call.
  localparam logic [13:0] VALID_MASK = 14'h1FFE;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  logic [13:0] sync1_q, sync2_q;
  logic [13:0] deb_q, deb_d;
  logic [13:0] rise_q;
  logic [13:0] lamp_q, lamp_d;
  logic [13:0] new_q;
  logic [13:0] accept;
  logic [7:0]  count_q, count_d;
  logic [3:0]  n_accept;
  logic [8:0]  count_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hc.rawHallButton & VALID_MASK;
      sync2_q <= sync1_q;
    end
  end

`ifdef HALL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar b = 0; b < 14; b++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_bit_d;

    // Dwell counter: any sample agreeing with deb restarts the count.
    always_comb begin
      cnt_d     = '0;
      deb_bit_d = deb_q[b];
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q == LAST) deb_bit_d = ~deb_q[b];
        else               cnt_d     = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign deb_d[b] = deb_bit_d;
  end
`else
  assign deb_d = sync2_q;
`endif

  // Served has priority over a coincident press edge.
  always_comb begin
    accept   = rise_q & ~lamp_q & ~hc.servedFloorButton;
    lamp_d   = (lamp_q | accept) & ~hc.servedFloorButton;
    n_accept = '0;
    for (int b = 0; b < 14; b++) begin
      n_accept = n_accept + {3'b000, accept[b]};
    end
    count_sum = {1'b0, count_q} + {5'b00000, n_accept};
    count_d   = count_sum[8] ? 8'hFF : count_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q   <= '0;
      rise_q  <= '0;
      lamp_q  <= '0;
      new_q   <= '0;
      count_q <= '0;
    end else begin
      deb_q   <= deb_d;
      rise_q  <= deb_d & ~deb_q;
      lamp_q  <= lamp_d;
      new_q   <= accept;
      count_q <= count_d;
    end
  end

  assign hc.newFloorButton = new_q;
  assign hc.hallLamp       = lamp_q;
  assign hc.callCount      = count_q;
endmodule

// File: tb/tb_hall_call_latch.sv
// Self-checking bench for hall_call_latch: vector table, corner sequences, random run vs model.
// Expectations follow HALL_DEBOUNCE_EN the same way the design does.
module tb_hall_call_latch;
  localparam int D = 4;
`ifdef HALL_DEBOUNCE_EN
  localparam int DM = D;
`else
  localparam int DM = 1;
`endif
  // Raw set up before edge N gives a pulse after edge N+LAT, i.e. on tick LAT+1.
  localparam int LAT = DM + 2;
  localparam int HL  = DM + 2;
  localparam logic [13:0] GLM = (DM <= 3) ? 14'h0010 : 14'h0000;
  localparam int GC = (DM <= 3) ? 1 : 0;

  logic clk, reset;
  hall_call_latch_if hc ();

  hall_call_latch #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .hc    (hc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a debounced level changes once the last DM synchronised samples
  // (two edges old) all disagree with it; lamps, pulses and count follow the call rules.
  logic [13:0] m_hist [HL];
  logic [13:0] m_deb, m_rise, m_lamp, m_new;
  logic [7:0]  m_count;

  always @(posedge clk or posedge reset) begin
    logic [13:0] acc, nd;
    logic        differ;
    int          sum;
    if (reset) begin
      for (int k = 0; k < HL; k++) m_hist[k] <= '0;
      m_deb <= '0; m_rise <= '0; m_lamp <= '0; m_new <= '0; m_count <= '0;
    end else begin
      acc = m_rise & ~m_lamp & ~hc.servedFloorButton;
      nd  = m_deb;
      for (int b = 0; b < 14; b++) begin
        differ = 1'b1;
        for (int k = 1; k <= DM; k++) if (m_hist[k][b] == m_deb[b]) differ = 1'b0;
        if (differ) nd[b] = ~m_deb[b];
      end
      sum = int'(m_count) + $countones(acc);
      m_rise  <= nd & ~m_deb;
      m_deb   <= nd;
      m_lamp  <= (m_lamp | acc) & ~hc.servedFloorButton;
      m_new   <= acc;
      m_count <= (sum > 255) ? 8'hFF : 8'(sum);
      m_hist[0] <= hc.rawHallButton & 14'h1FFE;
      for (int k = 1; k < HL; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  typedef struct {
    logic [13:0] raw;
    logic [13:0] served;
    int          cycles;
    logic [13:0] exp_lamp;
    int          exp_count;
    logic [13:0] exp_or;
    int          exp_np;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic [13:0] raw, logic [13:0] served, int cycles,
                              logic [13:0] lamp, int cnt, logic [13:0] por, int np);
    vec_t v;
    v.raw = raw; v.served = served; v.cycles = cycles;
    v.exp_lamp = lamp; v.exp_count = cnt; v.exp_or = por; v.exp_np = np;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hc.rawHallButton = '0;
    hc.servedFloorButton = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pulse(output int k);
    k = 0;
    while (k < 60) begin
      tick();
      k++;
      if (hc.newFloorButton != '0) break;
    end
  endtask

  initial begin
    logic [13:0] acc_or, r;
    int np, k;
    int hold [14];

    tbl[0]  = mk(14'h0000, 14'h0000,  5, 14'h0000,        0,       14'h0000, 0);
    tbl[1]  = mk(14'h0008, 14'h0000, 20, 14'h0008,        1,       14'h0008, 1);
    tbl[2]  = mk(14'h0000, 14'h0000, 10, 14'h0008,        1,       14'h0000, 0);
    tbl[3]  = mk(14'h2001, 14'h0000, 50, 14'h0008,        1,       14'h0000, 0);
    tbl[4]  = mk(14'h0010, 14'h0000,  3, 14'h0008,        1,       14'h0000, 0);
    tbl[5]  = mk(14'h0000, 14'h0000, 10, 14'h0008 | GLM,  1 + GC,  GLM,      GC);
    tbl[6]  = mk(14'h0000, 14'h0018,  1, 14'h0000,        1 + GC,  14'h0000, 0);
    tbl[7]  = mk(14'h0A54, 14'h0000, 20, 14'h0A54,        6 + GC,  14'h0A54, 5);
    tbl[8]  = mk(14'h0000, 14'h0000, 10, 14'h0A54,        6 + GC,  14'h0000, 0);
    tbl[9]  = mk(14'h0A54, 14'h0000, 20, 14'h0A54,        6 + GC,  14'h0000, 0);
    tbl[10] = mk(14'h0000, 14'h0000, 10, 14'h0A54,        6 + GC,  14'h0000, 0);
    tbl[11] = mk(14'h0000, 14'h0A54,  1, 14'h0000,        6 + GC,  14'h0000, 0);
    tbl[12] = mk(14'h0A54, 14'h0000, 20, 14'h0A54,        11 + GC, 14'h0A54, 5);

    do_reset();
    chk("reset_new",   hc.newFloorButton, 0);
    chk("reset_lamp",  hc.hallLamp,       0);
    chk("reset_count", hc.callCount,      0);

    for (int i = 0; i < 13; i++) begin
      hc.rawHallButton = tbl[i].raw;
      hc.servedFloorButton = tbl[i].served;
      acc_or = '0;
      np = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        tick();
        acc_or |= hc.newFloorButton;
        np += $countones(hc.newFloorButton);
      end
      hc.servedFloorButton = '0;
      chk($sformatf("row%0d_lamp", i),   hc.hallLamp,  tbl[i].exp_lamp);
      chk($sformatf("row%0d_count", i),  hc.callCount, tbl[i].exp_count);
      chk($sformatf("row%0d_pulsed", i), acc_or,       tbl[i].exp_or);
      chk($sformatf("row%0d_npulse", i), np,           tbl[i].exp_np);
    end

    // Served while held: lamp clears and the held button does not re-fire.
    do_reset();
    hc.rawHallButton = 14'h0020;
    wait_pulse(k);
    chk("b5_latency", k, LAT + 1);
    chk("b5_pulse", hc.newFloorButton, 14'h0020);
    tick();
    chk("b5_pulse_width", hc.newFloorButton, 0);
    chk("b5_lamp_on", hc.hallLamp, 14'h0020);
    hc.servedFloorButton = 14'h0020;
    tick();
    hc.servedFloorButton = '0;
    chk("b5_lamp_served", hc.hallLamp, 0);
    acc_or = '0;
    for (int c = 0; c < 20; c++) begin tick(); acc_or |= hc.newFloorButton; end
    chk("b5_no_refire", acc_or, 0);
    hc.rawHallButton = '0;
    for (int c = 0; c < 2 * DM + 4; c++) tick();
    hc.rawHallButton = 14'h0020;
    acc_or = '0;
    for (int c = 0; c < 20; c++) begin tick(); acc_or |= hc.newFloorButton; end
    chk("b5_repress_pulse", acc_or, 14'h0020);
    chk("b5_repress_count", hc.callCount, 2);

    // Served on the very edge the press would be accepted.
    do_reset();
    hc.rawHallButton = 14'h0080;
    for (int c = 0; c < LAT; c++) tick();
    hc.servedFloorButton = 14'h0080;
    tick();
    hc.servedFloorButton = '0;
    chk("b7_collide_new",  hc.newFloorButton, 0);
    chk("b7_collide_lamp", hc.hallLamp, 0);
    acc_or = '0;
    for (int c = 0; c < 20; c++) begin tick(); acc_or |= hc.newFloorButton; end
    chk("b7_collide_later", acc_or, 0);
    chk("b7_collide_count", hc.callCount, 0);

    // Asynchronous reset with a lamp on and another bit mid-debounce.
    do_reset();
    hc.rawHallButton = 14'h0008;
    wait_pulse(k);
    chk("rst_pre_pulse", hc.newFloorButton, 14'h0008);
    hc.rawHallButton = 14'h0108;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_new",   hc.newFloorButton, 0);
    chk("rst_async_lamp",  hc.hallLamp, 0);
    chk("rst_async_count", hc.callCount, 0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    wait_pulse(k);
    chk("rst_restart_latency", k, LAT + 1);
    chk("rst_restart_pulse", hc.newFloorButton, 14'h0108);

    // Saturation: 25 rounds of 12 simultaneous calls.
    do_reset();
    for (int rnd = 1; rnd <= 25; rnd++) begin
      hc.rawHallButton = 14'h3FFF;
      for (int c = 0; c < LAT + 2; c++) tick();
      hc.rawHallButton = '0;
      hc.servedFloorButton = 14'h3FFF;
      tick();
      hc.servedFloorButton = '0;
      for (int c = 0; c < 2 * DM + 4; c++) tick();
      if (rnd == 21) chk("sat_252", hc.callCount, 252);
    end
    chk("sat_255", hc.callCount, 255);
    chk("sat_lamp", hc.hallLamp, 0);

    // Random run against the model.
    do_reset();
    r = '0;
    for (int b = 0; b < 14; b++) hold[b] = $urandom_range(1, 8);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 14; b++) begin
        if (hold[b] == 0) begin
          r[b] = ~r[b];
          hold[b] = $urandom_range(1, 2 * DM + 4);
        end else begin
          hold[b]--;
        end
      end
      hc.rawHallButton = r;
      hc.servedFloorButton = ($urandom_range(0, 7) == 0) ? (14'($urandom) & 14'($urandom)) : 14'h0000;
      tick();
      chk("model", {28'h0, hc.newFloorButton, hc.hallLamp, hc.callCount},
                   {28'h0, m_new, m_lamp, m_count});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
